// File: rtl/logic_avalon_mm_to_axi4_lite.sv
// Avalon-MM slave to AXI4-Lite master bridge. One transaction in flight,
// independent AW/W handshakes, registered AXI valid/ready and Avalon responses.
module logic_avalon_mm_to_axi4_lite #(
  parameter int         DATA_BYTES    = 4,
  parameter int         ADDRESS_WIDTH = 1,
  parameter logic [2:0] PROT          = 3'b000
) (
  input  logic                       aclk,
  input  logic                       areset_n,
  input  logic                       slave_read,
  input  logic                       slave_write,
  input  logic [ADDRESS_WIDTH-1:0]   slave_address,
  input  logic [8*DATA_BYTES-1:0]    slave_writedata,
  input  logic [DATA_BYTES-1:0]      slave_byteenable,
  output logic                       slave_waitrequest,
  output logic [8*DATA_BYTES-1:0]    slave_readdata,
  output logic                       slave_readdatavalid,
  output logic                       slave_writeresponsevalid,
  output logic [1:0]                 slave_response,
  output logic                       master_awvalid,
  input  logic                       master_awready,
  output logic [ADDRESS_WIDTH-1:0]   master_awaddr,
  output logic [2:0]                 master_awprot,
  output logic                       master_wvalid,
  input  logic                       master_wready,
  output logic [8*DATA_BYTES-1:0]    master_wdata,
  output logic [DATA_BYTES-1:0]      master_wstrb,
  input  logic                       master_bvalid,
  output logic                       master_bready,
  input  logic [1:0]                 master_bresp,
  output logic                       master_arvalid,
  input  logic                       master_arready,
  output logic [ADDRESS_WIDTH-1:0]   master_araddr,
  output logic [2:0]                 master_arprot,
  input  logic                       master_rvalid,
  output logic                       master_rready,
  input  logic [8*DATA_BYTES-1:0]    master_rdata,
  input  logic [1:0]                 master_rresp
);

  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [2:0] {IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]            wdata_q, wdata_d;
  logic [DATA_BYTES-1:0]    wstrb_q, wstrb_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic [DW-1:0]            readdata_q, readdata_d;
  logic [1:0]               response_q, response_d;
  logic                     rdv_q, rdv_d;
  logic                     wrv_q, wrv_d;
  logic                     aw_fire, w_fire;

  // EXOKAY has no Avalon counterpart and is reported as OKAY.
  function automatic logic [1:0] map_resp(input logic [1:0] axi_resp);
    return (axi_resp == 2'b01) ? 2'b00 : axi_resp;
  endfunction

  assign aw_fire = awvalid_q && master_awready;
  assign w_fire  = wvalid_q && master_wready;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through the case infers a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    readdata_d = readdata_q;
    response_d = response_q;
    rdv_d      = 1'b0;
    wrv_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (slave_write) begin
          state_d   = WRITE;
          addr_d    = slave_address;
          wdata_d   = slave_writedata;
          wstrb_d   = slave_byteenable;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else if (slave_read) begin
          state_d   = READ_ADDR;
          addr_d    = slave_address;
          arvalid_d = 1'b1;
        end
      end
      WRITE: begin
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        // A channel whose valid is already low finished its handshake earlier.
        if ((aw_fire || !awvalid_q) && (w_fire || !wvalid_q)) begin
          state_d  = WRITE_RESP;
          bready_d = 1'b1;
        end
      end
      WRITE_RESP: begin
        if (master_bvalid) begin
          state_d    = IDLE;
          bready_d   = 1'b0;
          wrv_d      = 1'b1;
          response_d = map_resp(master_bresp);
        end
      end
      READ_ADDR: begin
        if (master_arready) begin
          state_d   = READ_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      READ_DATA: begin
        if (master_rvalid) begin
          state_d    = IDLE;
          rready_d   = 1'b0;
          rdv_d      = 1'b1;
          readdata_d = master_rdata;
          response_d = map_resp(master_rresp);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      readdata_q <= '0;
      response_q <= 2'b00;
      rdv_q      <= 1'b0;
      wrv_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      readdata_q <= readdata_d;
      response_q <= response_d;
      rdv_q      <= rdv_d;
      wrv_q      <= wrv_d;
    end
  end

  // Reset forces the stall directly, since IDLE alone would otherwise release it.
  assign slave_waitrequest        = (state_q != IDLE) || !areset_n;
  assign slave_readdata           = readdata_q;
  assign slave_readdatavalid      = rdv_q;
  assign slave_writeresponsevalid = wrv_q;
  assign slave_response           = response_q;
  assign master_awvalid           = awvalid_q;
  assign master_awaddr            = addr_q;
  assign master_awprot            = PROT;
  assign master_wvalid            = wvalid_q;
  assign master_wdata             = wdata_q;
  assign master_wstrb             = wstrb_q;
  assign master_bready            = bready_q;
  assign master_arvalid           = arvalid_q;
  assign master_araddr            = addr_q;
  assign master_arprot            = PROT;
  assign master_rready            = rready_q;

endmodule

// File: tb/tb_logic_avalon_mm_to_axi4_lite.sv
// Bench for the Avalon-MM to AXI4-Lite bridge: an AXI slave responder with
// programmable stalls, and a word-memory reference model at the Avalon level.
module tb_logic_avalon_mm_to_axi4_lite;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        slave_read, slave_write;
  logic [31:0] slave_address, slave_writedata;
  logic [3:0]  slave_byteenable;
  logic        slave_waitrequest;
  logic [31:0] slave_readdata;
  logic        slave_readdatavalid, slave_writeresponsevalid;
  logic [1:0]  slave_response;
  logic        master_awvalid, master_awready;
  logic [31:0] master_awaddr;
  logic [2:0]  master_awprot;
  logic        master_wvalid, master_wready;
  logic [31:0] master_wdata;
  logic [3:0]  master_wstrb;
  logic        master_bvalid, master_bready;
  logic [1:0]  master_bresp;
  logic        master_arvalid, master_arready;
  logic [31:0] master_araddr;
  logic [2:0]  master_arprot;
  logic        master_rvalid, master_rready;
  logic [31:0] master_rdata;
  logic [1:0]  master_rresp;

  logic_avalon_mm_to_axi4_lite #(
    .DATA_BYTES(4), .ADDRESS_WIDTH(32), .PROT(3'b000)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .slave_read(slave_read), .slave_write(slave_write),
    .slave_address(slave_address), .slave_writedata(slave_writedata),
    .slave_byteenable(slave_byteenable), .slave_waitrequest(slave_waitrequest),
    .slave_readdata(slave_readdata), .slave_readdatavalid(slave_readdatavalid),
    .slave_writeresponsevalid(slave_writeresponsevalid), .slave_response(slave_response),
    .master_awvalid(master_awvalid), .master_awready(master_awready),
    .master_awaddr(master_awaddr), .master_awprot(master_awprot),
    .master_wvalid(master_wvalid), .master_wready(master_wready),
    .master_wdata(master_wdata), .master_wstrb(master_wstrb),
    .master_bvalid(master_bvalid), .master_bready(master_bready),
    .master_bresp(master_bresp),
    .master_arvalid(master_arvalid), .master_arready(master_arready),
    .master_araddr(master_araddr), .master_arprot(master_arprot),
    .master_rvalid(master_rvalid), .master_rready(master_rready),
    .master_rdata(master_rdata), .master_rresp(master_rresp)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Responder knobs: cycles of valid/ready seen before the slave answers.
  int         aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;

  logic [31:0] axi_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [1:0]  resp_map [4] = '{2'b00, 2'b00, 2'b10, 2'b11};

  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // AXI4-Lite slave responder; drives its ready/valid at the falling edge.
  initial begin
    master_awready = 1'b0; master_wready = 1'b0; master_arready = 1'b0;
    master_bvalid = 1'b0; master_bresp = 2'b00;
    master_rvalid = 1'b0; master_rdata = '0; master_rresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (master_awvalid) begin
        master_awready = (aw_cnt >= aw_delay);
        if (master_awready) cap_awaddr = master_awaddr;
        aw_cnt++;
      end else begin master_awready = 1'b0; aw_cnt = 0; end
      if (master_wvalid) begin
        master_wready = (w_cnt >= w_delay);
        if (master_wready) begin cap_wdata = master_wdata; cap_wstrb = master_wstrb; end
        w_cnt++;
      end else begin master_wready = 1'b0; w_cnt = 0; end
      if (master_arvalid) begin
        master_arready = (ar_cnt >= ar_delay);
        if (master_arready) cap_araddr = master_araddr;
        ar_cnt++;
      end else begin master_arready = 1'b0; ar_cnt = 0; end
      if (master_bready) begin
        master_bvalid = (b_cnt >= b_delay);
        master_bresp  = bresp_val;
        if (master_bvalid)
          axi_mem[cap_awaddr] = merge(axi_mem.exists(cap_awaddr) ? axi_mem[cap_awaddr] : 32'h0,
                                      cap_wdata, cap_wstrb);
        b_cnt++;
      end else begin master_bvalid = 1'b0; b_cnt = 0; end
      if (master_rready) begin
        master_rvalid = (r_cnt >= r_delay);
        master_rresp  = rresp_val;
        master_rdata  = axi_mem.exists(cap_araddr) ? axi_mem[cap_araddr] : 32'h0;
        r_cnt++;
      end else begin
        master_rvalid = 1'b0; r_cnt = 0;
        master_rdata  = $urandom();
      end
    end
  end

  task automatic run_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                           input logic [1:0] br, input int daw, input int dw, input int db,
                           input string tag);
    int lat = -1, pulses = 0, aw_hi = 0, w_hi = 0, b_hi = 0, exp_lat;
    exp_lat = 3 + ((daw > dw) ? daw : dw) + db;
    aw_delay = daw; w_delay = dw; b_delay = db; bresp_val = br;
    @(negedge aclk);
    slave_address = addr; slave_writedata = data; slave_byteenable = be; slave_write = 1'b1;
    check({tag, " accept_wait"}, slave_waitrequest, 0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge aclk);
      if (c == 1) begin
        slave_write = 1'b0;
        check({tag, " awvalid"}, master_awvalid, 1);
        check({tag, " wvalid"}, master_wvalid, 1);
        check({tag, " wdata"}, master_wdata, data);
        check({tag, " wstrb"}, master_wstrb, be);
      end
      if (master_awvalid) begin aw_hi++; check({tag, " awaddr"}, master_awaddr, addr); end
      if (master_wvalid) w_hi++;
      if (master_bready) b_hi++;
      if (slave_writeresponsevalid) begin
        pulses++;
        if (lat < 0) lat = c;
        check({tag, " bresp"}, slave_response, resp_map[br]);
      end else if (lat < 0) begin
        check({tag, " busy_wait"}, slave_waitrequest, 1);
      end else begin
        check({tag, " resp_hold"}, slave_response, resp_map[br]);
      end
      if (lat >= 0 && c == lat + 1) break;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " aw_cycles"}, aw_hi, daw + 1);
    check({tag, " w_cycles"}, w_hi, dw + 1);
    check({tag, " b_cycles"}, b_hi, db + 1);
    ref_mem[addr] = merge(ref_word(addr), data, be);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [1:0] rr, input int dar,
                          input int dr, input string tag);
    int lat = -1, pulses = 0, ar_hi = 0, r_hi = 0, exp_lat;
    logic [31:0] expd;
    exp_lat = 3 + dar + dr;
    expd = ref_word(addr);
    ar_delay = dar; r_delay = dr; rresp_val = rr;
    @(negedge aclk);
    slave_address = addr; slave_read = 1'b1;
    check({tag, " accept_wait"}, slave_waitrequest, 0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge aclk);
      if (c == 1) begin
        slave_read = 1'b0;
        check({tag, " arvalid"}, master_arvalid, 1);
        check({tag, " araddr"}, master_araddr, addr);
      end
      if (master_arvalid) ar_hi++;
      if (master_rready) r_hi++;
      if (slave_readdatavalid) begin
        pulses++;
        if (lat < 0) lat = c;
        check({tag, " rdata"}, slave_readdata, expd);
        check({tag, " rresp"}, slave_response, resp_map[rr]);
      end else if (lat < 0) begin
        check({tag, " busy_wait"}, slave_waitrequest, 1);
      end else begin
        check({tag, " rdata_hold"}, slave_readdata, expd);
      end
      if (lat >= 0 && c == lat + 1) break;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " ar_cycles"}, ar_hi, dar + 1);
    check({tag, " r_cycles"}, r_hi, dr + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wp, rp, ar_early, seen;
    logic [31:0] a, d;
    logic [3:0]  be;
    slave_read = 1'b0; slave_write = 1'b0;
    slave_address = '0; slave_writedata = '0; slave_byteenable = '0;
    axi_mem[32'h8] = 32'h1234_5678;
    ref_mem[32'h8] = 32'h1234_5678;

    areset_n = 1'b1;
    #1 areset_n = 1'b0;
    #2;
    check("rst waitrequest", slave_waitrequest, 1);
    check("rst awvalid", master_awvalid, 0);
    check("rst wvalid", master_wvalid, 0);
    check("rst bready", master_bready, 0);
    check("rst arvalid", master_arvalid, 0);
    check("rst rready", master_rready, 0);
    check("rst rdv", slave_readdatavalid, 0);
    check("rst wrv", slave_writeresponsevalid, 0);
    check("rst readdata", slave_readdata, 0);
    check("rst response", slave_response, 0);
    check("rst prot", {master_awprot, master_arprot}, 6'b0);
    @(negedge aclk); @(negedge aclk);
    areset_n = 1'b1;

    run_write(32'h4, 32'hDEAD_BEEF, 4'b0011, 2'b00, 0, 0, 0, "wr_single");
    run_read(32'h8, 2'b10, 0, 0, "rd_single");
    run_read(32'h4, 2'b00, 0, 0, "rd_after_wr");
    run_write(32'hC, 32'hA5A5_0F0F, 4'b1111, 2'b10, 3, 0, 0, "wr_aw_stall");
    run_write(32'h0, 32'h0BAD_F00D, 4'b1100, 2'b11, 0, 2, 10, "wr_b_stall");

    // Write and read asserted together: write first, read at the next IDLE cycle.
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    bresp_val = 2'b01; rresp_val = 2'b11;
    @(negedge aclk);
    slave_address = 32'hC; slave_writedata = 32'h1357_9BDF; slave_byteenable = 4'hF;
    slave_write = 1'b1; slave_read = 1'b1;
    check("b2b accept_wait", slave_waitrequest, 0);
    ref_mem[32'hC] = 32'h1357_9BDF;
    wp = 0; rp = 0; ar_early = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge aclk);
      if (c == 1) slave_write = 1'b0;
      if (c == 4) slave_read = 1'b0;
      if (c <= 3 && master_arvalid) ar_early++;
      if (c == 3) begin
        check("b2b wrv", slave_writeresponsevalid, 1);
        check("b2b exokay", slave_response, 2'b00);
        check("b2b idle_wait", slave_waitrequest, 0);
      end
      if (c == 4) check("b2b arvalid", master_arvalid, 1);
      if (c == 6) begin
        check("b2b rdv", slave_readdatavalid, 1);
        check("b2b rdata", slave_readdata, 32'h1357_9BDF);
        check("b2b decerr", slave_response, 2'b11);
      end
      wp += int'(slave_writeresponsevalid);
      rp += int'(slave_readdatavalid);
    end
    check("b2b wr_pulses", wp, 1);
    check("b2b rd_pulses", rp, 1);
    check("b2b ar_early", ar_early, 0);

    for (int i = 0; i < 24; i++) begin
      a  = 32'($urandom_range(0, 3) * 4);
      d  = $urandom();
      be = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1)
        run_write(a, d, be, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), "rnd_wr");
      else
        run_read(a, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                 $urandom_range(0, 3), "rnd_rd");
    end

    // Reset while waiting for read data: transaction abandoned, no response.
    ar_delay = 0; r_delay = 30; rresp_val = 2'b00;
    @(negedge aclk);
    slave_address = 32'h8; slave_read = 1'b1;
    @(negedge aclk);
    slave_read = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge aclk);
      if (master_rready) seen = 1;
    end
    check("rstmid reached_read_data", seen, 1);
    areset_n = 1'b0;
    #1;
    check("rstmid arvalid", master_arvalid, 0);
    check("rstmid rready", master_rready, 0);
    check("rstmid rdv", slave_readdatavalid, 0);
    check("rstmid waitrequest", slave_waitrequest, 1);
    @(negedge aclk); @(negedge aclk);
    areset_n = 1'b1;
    r_delay = 0;
    rp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      rp += int'(slave_readdatavalid);
    end
    check("rstmid no_response", rp, 0);
    check("rstmid idle", slave_waitrequest, 0);
    run_read(32'h8, 2'b10, 1, 2, "rd_after_rst");
    run_write(32'h8, 32'hCAFE_0001, 4'b0101, 2'b00, 1, 1, 1, "wr_after_rst");
    run_read(32'h8, 2'b01, 0, 0, "rd_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
